// File: rtl/memoria_personalizada_if.sv
// Record/read bus of the customisable sequence memory.
// The datapath/control side is the master; the memory is the slave.
interface memoria_personalizada_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 4
);
    logic                 inicia_gravacao;
    logic                 finaliza_gravacao;
    logic [DATA_BITS-1:0] botoes;
    logic [ADDR_BITS-1:0] address;
    logic [DATA_BITS-1:0] data_out;
    logic                 gravando;
    logic [ADDR_BITS:0]   tamanho;
    logic                 cheia;
    logic                 pronto;
    logic                 erro_jogada;
    logic [1:0]           db_estado;

    modport master (
        output inicia_gravacao, finaliza_gravacao, botoes, address,
        input  data_out, gravando, tamanho, cheia, pronto, erro_jogada, db_estado
    );

    modport slave (
        input  inicia_gravacao, finaliza_gravacao, botoes, address,
        output data_out, gravando, tamanho, cheia, pronto, erro_jogada, db_estado
    );
endinterface

// File: rtl/memoria_personalizada.sv
// Writable sequence memory filled by button presses, with a ROM-like registered read port.
// A three-state recorder takes one one-hot press per activation and waits for release.
module memoria_personalizada #(
    parameter int                   DEPTH        = 16,
    parameter int                   ADDR_BITS    = 4,
    parameter int                   DATA_BITS    = 4,
    parameter logic [DATA_BITS-1:0] VALOR_PADRAO = DATA_BITS'(1)
) (
    input logic                    clock,
    input logic                    reset,
    memoria_personalizada_if.slave bus
);
    localparam int                 IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS:0] CHEIO = (ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        GRAVANDO = 2'd1,
        SOLTA    = 2'd2
    } estado_t;

    estado_t              estado, proximo;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] dado;
    logic [ADDR_BITS:0]   tamanho;
    logic                 pronto, erro;
    logic                 escreve, limpa, pronto_d, erro_d;
    logic                 nenhum, um_so;

    assign nenhum = (bus.botoes == '0);
    // Clearing the lowest set bit leaves zero only for a single-bit value.
    assign um_so  = !nenhum && ((bus.botoes & (bus.botoes - DATA_BITS'(1))) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= proximo;
    end

    always_comb begin
        proximo  = estado;
        escreve  = 1'b0;
        limpa    = 1'b0;
        pronto_d = 1'b0;
        erro_d   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.inicia_gravacao) begin
                    proximo = GRAVANDO;
                    limpa   = 1'b1;
                end
            end
            GRAVANDO: begin
                // Ending wins over a press arriving in the same cycle.
                if (bus.finaliza_gravacao) begin
                    proximo  = OCIOSO;
                    pronto_d = 1'b1;
                end else if (um_so) begin
                    escreve = 1'b1;
                    proximo = SOLTA;
                end else if (!nenhum) begin
                    erro_d  = 1'b1;
                    proximo = SOLTA;
                end
            end
            SOLTA: begin
                if (bus.finaliza_gravacao) begin
                    proximo  = OCIOSO;
                    pronto_d = 1'b1;
                end else if (nenhum) begin
                    if (tamanho == CHEIO) begin
                        proximo  = OCIOSO;
                        pronto_d = 1'b1;
                    end else begin
                        proximo = GRAVANDO;
                    end
                end
            end
            default: proximo = OCIOSO;
        endcase
    end

    // tamanho doubles as the write pointer; it stops at DEPTH because a full
    // memory always leaves SOLTA for OCIOSO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tamanho <= '0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
        end else begin
            pronto <= pronto_d;
            erro   <= erro_d;
            if (limpa)
                tamanho <= '0;
            else if (escreve && tamanho != CHEIO)
                tamanho <= tamanho + (ADDR_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= VALOR_PADRAO;
        end else if (escreve && tamanho != CHEIO) begin
            mem[tamanho[IDX_W-1:0]] <= bus.botoes;
        end
    end

    // Read in every state; a same-address write lands after this sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dado <= VALOR_PADRAO;
        else        dado <= mem[bus.address[IDX_W-1:0]];
    end

    assign bus.data_out    = dado;
    assign bus.gravando    = (estado != OCIOSO);
    assign bus.tamanho     = tamanho;
    assign bus.cheia       = (tamanho == CHEIO);
    assign bus.pronto      = pronto;
    assign bus.erro_jogada = erro;
    assign bus.db_estado   = estado;
endmodule
